bcd_updown_timer: RTL

Parametrised BCD up/down timer core with load, start/pause, optional wrap, and a terminal-count pulse. Counts directly in BCD, so no binary-to-decimal conversion stage is needed. Advances on an external `tick` enable, which is one `clk` cycle wide and comes from the shared clock divider. The digit vector feeds the existing seven-segment display scanner unchanged.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 42 ++++
 rtl/bcd_updown_timer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD up/down timer.
// The state encoding is what appears on state_o and the debug LEDs.
package timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  localparam int SEL_DIR  = 1;
  localparam int SEL_LOAD = 0;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles in a preset are treated as 9.
  function automatic logic [3:0] clampBcd(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer: a 4-bit register that loads, counts up or down,
// and passes carry/borrow to the next more significant digit.
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] value,
  output logic       cout,
  output logic       bout
);

  logic [3:0] r_q;
  logic       w_up;
  logic       w_dn;

  assign w_up  = inc & cin;
  assign w_dn  = dec & bin;
  assign cout  = w_up & (r_q == BCD_MAX);
  assign bout  = w_dn & (r_q == 4'd0);
  assign value = r_q;

  // Load wins over counting so IDLE/abort always show a clean preset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 4'd0;
    end else if (load) begin
      r_q <= load_val;
    end else if (w_up) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end else if (w_dn) begin
      r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// BCD up/down timer: button synchroniser, preset mux, control FSM and a
// chain of bcd_digit registers that count directly in decimal.
module bcd_updown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter bit          WRAP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start_btn,
  input  logic              abort,
  input  logic [1:0]        select,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] digits,
  output logic              running,
  output logic              done,
  output logic [2:0]        state_o
);

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;
  logic r_dir;
  logic r_running;
  logic r_done;

  logic [4*NDIG-1:0] w_preset;
  logic [4*NDIG-1:0] w_digits;
  logic [NDIG:0]     w_carry;
  logic [NDIG:0]     w_borrow;
  logic              w_atTerm;
  logic              w_load;
  logic              w_stepUp;
  logic              w_stepDn;
  logic              w_doneNext;

  always_comb begin
    w_preset = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (select[SEL_LOAD]) begin
        w_preset[4*i +: 4] = clampBcd(load_val[4*i +: 4]);
      end else begin
        w_preset[4*i +: 4] = select[SEL_DIR] ? BCD_MAX : 4'd0;
      end
    end
  end

  assign w_atTerm = r_dir ? (w_digits == '0) : (w_digits == {NDIG{BCD_MAX}});

  // The two-flop synchroniser and edge detector are kept through abort so a
  // held button cannot produce a second press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= start_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (r_rise) w_next = S_RUN;
        S_RUN: begin
          if (!WRAP && w_atTerm) begin
            w_next = S_DONE;
          end else if (r_rise) begin
            w_next = S_PAUSE;
          end
        end
        S_PAUSE: if (r_rise) w_next = S_RUN;
        S_DONE:  if (r_rise) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_load   = (r_state == S_IDLE) || (w_next == S_IDLE);
  assign w_stepUp = (r_state == S_RUN) & tick & ~abort & ~r_dir & ~(!WRAP && w_atTerm);
  assign w_stepDn = (r_state == S_RUN) & tick & ~abort &  r_dir & ~(!WRAP && w_atTerm);

  // With wrapping, a carry/borrow out of the top digit is exactly the wrap event.
  assign w_doneNext = WRAP ? (w_carry[NDIG] | w_borrow[NDIG])
                           : (~abort & (r_state == S_RUN) & w_atTerm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      r_done    <= w_doneNext;
      if (abort) begin
        r_dir <= 1'b0;
      end else if (r_state == S_IDLE && w_next == S_RUN) begin
        r_dir <= select[SEL_DIR];
      end
    end
  end

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < int'(NDIG); g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .inc      (w_stepUp),
      .dec      (w_stepDn),
      .load     (w_load),
      .load_val (w_preset[4*g +: 4]),
      .cin      (w_carry[g]),
      .bin      (w_borrow[g]),
      .value    (w_digits[4*g +: 4]),
      .cout     (w_carry[g+1]),
      .bout     (w_borrow[g+1])
    );
  end

  assign digits  = w_digits;
  assign running = r_running;
  assign done    = r_done;
  assign state_o = r_state;

endmodule
